// File: rtl/ps2_pkg.sv
// Shared frame layout constants, transmitter state encoding and the frame
// validity rule for the PS/2 receiver.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int START_IDX  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PAR_IDX    = 9;
  localparam int STOP_IDX   = 10;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_WAIT  = 2'd1,
    TX_SHIFT = 2'd2
  } tx_state_t;

  // The frame is good when start is low, stop is high, and data plus parity
  // hold an odd number of ones.
  function automatic logic frame_good(input logic [FRAME_BITS-1:0] f);
    return (f[START_IDX] == 1'b0) && (f[STOP_IDX] == 1'b1) && (^f[PAR_IDX:DATA_LSB]);
  endfunction

endpackage

// File: rtl/ps2_serial_tx.sv
// Free-running serial clock divider plus a byte transmitter that shifts data
// LSB first, changing bits on serial_clk falling edges only.
module ps2_serial_tx
  import ps2_pkg::*;
#(
  parameter int SER_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       serial_clk,
  output logic       serial_clk_out,
  output logic       serial_out
);

  localparam int DIV_W = (SER_DIV > 1) ? $clog2(SER_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_reg;
  logic             sclk_reg;
  logic             div_wrap;
  logic             sclk_fall;

  tx_state_t        state_reg, state_next;
  logic [7:0]       byte_reg, byte_next;
  logic [2:0]       idx_reg, idx_next;
  logic             sout_reg, sout_next;

  assign div_wrap  = (div_cnt_reg == DIV_W'(SER_DIV - 1));
  assign sclk_fall = div_wrap & sclk_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
      state_reg   <= TX_IDLE;
      byte_reg    <= '0;
      idx_reg     <= '0;
      sout_reg    <= 1'b1;
    end else begin
      if (div_wrap) begin
        div_cnt_reg <= '0;
        sclk_reg    <= ~sclk_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
      state_reg <= state_next;
      byte_reg  <= byte_next;
      idx_reg   <= idx_next;
      sout_reg  <= sout_next;
    end
  end

  // Bits leave from byte_reg[0]; the register shifts right as each bit goes out.
  always_comb begin
    state_next = state_reg;
    byte_next  = byte_reg;
    idx_next   = idx_reg;
    sout_next  = sout_reg;
    case (state_reg)
      TX_IDLE: begin
        if (load) begin
          byte_next  = load_data;
          state_next = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (sclk_fall) begin
          sout_next  = byte_reg[0];
          byte_next  = {1'b0, byte_reg[7:1]};
          idx_next   = '0;
          state_next = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (sclk_fall) begin
          if (idx_reg == 3'd7) begin
            sout_next  = 1'b1;
            state_next = TX_IDLE;
          end else begin
            sout_next = byte_reg[0];
            byte_next = {1'b0, byte_reg[7:1]};
            idx_next  = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        sout_next  = 1'b1;
        state_next = TX_IDLE;
      end
    endcase
  end

  assign serial_clk     = sclk_reg;
  assign serial_clk_out = (state_reg == TX_SHIFT) & sclk_reg;
  assign serial_out     = sout_reg;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronises the PS/2 lines, assembles and
// checks 11-bit frames, and forwards good data bytes to the serial transmitter.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SER_DIV        = 4
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  ps2_nclk,
  input  logic                  ndata,
  output logic [FRAME_BITS-1:0] serial_data,
  output logic                  valid,
  output logic                  led,
  output logic                  serial_clk,
  output logic                  serial_clk_out,
  output logic                  serial_out
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  // Index 0 carries the PS/2 clock, index 1 the PS/2 data.
  logic [1:0] sync_in;
  logic [1:0] s1_reg;
  logic [1:0] s2_reg;

  assign sync_in = {ndata, ps2_nclk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
          s1_reg[gi] <= 1'b1;
          s2_reg[gi] <= 1'b1;
        end else begin
          s1_reg[gi] <= sync_in[gi];
          s2_reg[gi] <= s1_reg[gi];
        end
      end
    end
  endgenerate

  logic                  clk_prev_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [3:0]            bit_cnt_reg;
  logic [IDLE_W-1:0]     idle_cnt_reg;
  logic [FRAME_BITS-1:0] serial_data_reg;
  logic                  valid_reg;
  logic                  led_reg;

  logic                  fall;
  logic                  last_bit;
  logic [FRAME_BITS-1:0] shifted;

  assign fall     = clk_prev_reg & ~s2_reg[0];
  assign last_bit = (bit_cnt_reg == 4'(FRAME_BITS - 1));
  assign shifted  = {s2_reg[1], shift_reg[FRAME_BITS-1:1]};

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      clk_prev_reg    <= 1'b1;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      idle_cnt_reg    <= '0;
      serial_data_reg <= '0;
      valid_reg       <= 1'b0;
      led_reg         <= 1'b0;
    end else begin
      clk_prev_reg <= s2_reg[0];
      valid_reg    <= 1'b0;
      if (fall) begin
        idle_cnt_reg <= '0;
        if (last_bit) begin
          serial_data_reg <= shifted;
          shift_reg       <= '0;
          bit_cnt_reg     <= '0;
          valid_reg       <= frame_good(shifted);
          led_reg         <= ~frame_good(shifted);
        end else begin
          shift_reg   <= shifted;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end else if (bit_cnt_reg != 4'd0) begin
        // A stalled partial frame is discarded; the last good frame stays visible.
        if (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          idle_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
          shift_reg    <= '0;
          led_reg      <= 1'b1;
        end else begin
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
      end else begin
        idle_cnt_reg <= '0;
      end
    end
  end

  assign serial_data = serial_data_reg;
  assign valid       = valid_reg;
  assign led         = led_reg;

  // The transmitter sees each good frame one cycle after valid rises; frames
  // arriving while it is busy are ignored there.
  ps2_serial_tx #(
    .SER_DIV(SER_DIV)
  ) u_tx (
    .clk           (Clk),
    .rst_n         (nReset),
    .load          (valid_reg),
    .load_data     (serial_data_reg[DATA_MSB:DATA_LSB]),
    .serial_clk    (serial_clk),
    .serial_clk_out(serial_clk_out),
    .serial_out    (serial_out)
  );

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed and randomized frames against a frame-level reference model of the
// PS/2 receiver and its serial re-transmitter.
module tb_ps2_receiver;

  localparam int TIMEOUT = 1000;
  localparam int SDIV    = 8;
  localparam int HALF    = 5;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        ps2_nclk;
  logic        ndata;
  logic [10:0] serial_data;
  logic        valid;
  logic        led;
  logic        serial_clk;
  logic        serial_clk_out;
  logic        serial_out;

  ps2_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SER_DIV       (SDIV)
  ) dut (
    .Clk           (Clk),
    .nReset        (nReset),
    .ps2_nclk      (ps2_nclk),
    .ndata         (ndata),
    .serial_data   (serial_data),
    .valid         (valid),
    .led           (led),
    .serial_clk    (serial_clk),
    .serial_clk_out(serial_clk_out),
    .serial_out    (serial_out)
  );

  always #5 Clk = ~Clk;

  int   errors = 0;
  int   checks = 0;
  int   valid_cnt = 0;
  logic sco_prev = 1'b0;
  logic tx_q[$];

  // Monitors: count valid pulses and capture serial_out at each serial_clk_out rise.
  always @(negedge Clk) begin
    if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
    sco_prev <= serial_clk_out;
    if (serial_clk_out === 1'b1 && sco_prev === 1'b0) tx_q.push_back(serial_out);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      ndata = f[i];
      repeat (HALF) @(negedge Clk);
      ps2_nclk = 1'b0;
      repeat (HALF) @(negedge Clk);
      ps2_nclk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic st, input logic [7:0] d,
                                           input logic p, input logic sp);
    return {sp, p, d, st};
  endfunction

  function automatic logic model_good(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (($countones(f[9:1]) % 2) == 1);
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_sdata"}, 32'(serial_data), 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_led"}, 32'(led), 32'h0);
    check({tag, "_sclk"}, 32'(serial_clk), 32'h0);
    check({tag, "_sclko"}, 32'(serial_clk_out), 32'h0);
    check({tag, "_sout"}, 32'(serial_out), 32'h1);
  endtask

  // Send one frame and compare capture, strobe, led and the re-transmitted byte.
  task automatic run_frame(input string tag, input logic [10:0] f);
    int          v0;
    int          q0;
    logic        good;
    logic [7:0]  got;
    good = model_good(f);
    v0   = valid_cnt;
    q0   = tx_q.size();
    send_bits(f, 11);
    repeat (10) @(negedge Clk);
    check({tag, "_sdata"}, 32'(serial_data), 32'(f));
    check({tag, "_valid"}, 32'(valid_cnt - v0), 32'(good));
    check({tag, "_led"}, 32'(led), 32'(!good));
    repeat (20 * SDIV + 20) @(negedge Clk);
    check({tag, "_txbits"}, 32'(tx_q.size() - q0), good ? 32'd8 : 32'd0);
    if (good && tx_q.size() >= q0 + 8) begin
      got = '0;
      for (int i = 0; i < 8; i++) got[i] = tx_q[q0 + i];
      check({tag, "_txbyte"}, 32'(got), 32'(f[8:1]));
    end
    check({tag, "_sout_idle"}, 32'(serial_out), 32'h1);
  endtask

  logic [10:0] f1, f2, prev_sd;
  logic [7:0]  rd, got8;
  int          v0, q0, rises, first, second;
  logic        p;

  initial begin
    nReset   = 1'b0;
    ps2_nclk = 1'b1;
    ndata    = 1'b1;
    repeat (3) @(negedge Clk);
    reset_checks("reset");
    nReset = 1'b1;

    // serial_clk free-runs with period 2*SDIV
    rises = 0; first = 0; second = 0; p = serial_clk;
    for (int i = 0; i < 200 && rises < 2; i++) begin
      @(negedge Clk);
      if (serial_clk && !p) begin
        rises++;
        if (rises == 1) first = i; else second = i;
      end
      p = serial_clk;
    end
    check("sclk_period", 32'(second - first), 32'(2 * SDIV));

    run_frame("good_1c", mk_frame(1'b0, 8'h1C, 1'b0, 1'b1));
    check("good_1c_value", 32'(serial_data), 32'h438);
    run_frame("badpar_1c", mk_frame(1'b0, 8'h1C, 1'b1, 1'b1));
    check("badpar_value", 32'(serial_data), 32'h638);
    run_frame("stop0_1c", mk_frame(1'b0, 8'h1C, 1'b0, 1'b0));
    check("stop0_value", 32'(serial_data), 32'h038);
    run_frame("good_again", mk_frame(1'b0, 8'h5A, 1'b1, 1'b1));

    // Timeout: five bits then a long idle-high clock
    prev_sd = serial_data;
    v0 = valid_cnt;
    send_bits(mk_frame(1'b0, 8'hF0, 1'b1, 1'b1), 5);
    repeat (TIMEOUT + 20) @(negedge Clk);
    check("timeout_led", 32'(led), 32'h1);
    check("timeout_sdata", 32'(serial_data), 32'(prev_sd));
    check("timeout_valid", 32'(valid_cnt - v0), 32'h0);
    run_frame("after_to", mk_frame(1'b0, 8'hF0, 1'b1, 1'b1));
    check("after_to_value", 32'(serial_data), 32'h7E0);

    // Reset mid-frame after a bad frame left led high
    run_frame("pre_rst_bad", mk_frame(1'b1, 8'h33, 1'b1, 1'b1));
    v0 = valid_cnt;
    send_bits(mk_frame(1'b0, 8'hA5, 1'b1, 1'b1), 6);
    @(negedge Clk);
    nReset = 1'b0;
    #1;
    reset_checks("midrst");
    check("midrst_novalid", 32'(valid_cnt - v0), 32'h0);
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    run_frame("post_rst", mk_frame(1'b0, 8'h3C, 1'b1, 1'b1));

    // Back-to-back good frames: second arrives mid-transmission and is dropped
    f1 = mk_frame(1'b0, 8'h81, 1'b1, 1'b1);
    f2 = mk_frame(1'b0, 8'h7E, 1'b1, 1'b1);
    v0 = valid_cnt;
    q0 = tx_q.size();
    send_bits(f1, 11);
    send_bits(f2, 11);
    repeat (10) @(negedge Clk);
    check("b2b_sdata", 32'(serial_data), 32'(f2));
    check("b2b_valid", 32'(valid_cnt - v0), 32'h2);
    check("b2b_led", 32'(led), 32'h0);
    repeat (40 * SDIV) @(negedge Clk);
    check("b2b_txbits", 32'(tx_q.size() - q0), 32'd8);
    if (tx_q.size() >= q0 + 8) begin
      got8 = '0;
      for (int i = 0; i < 8; i++) got8[i] = tx_q[q0 + i];
      check("b2b_txbyte", 32'(got8), 32'(f1[8:1]));
    end

    // Randomized frames, occasionally corrupting start, parity or stop
    for (int n = 0; n < 10; n++) begin
      rd = 8'($urandom_range(0, 255));
      f1 = mk_frame(($urandom_range(0, 7) == 0), rd,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
      $display("rand frame %0d: 0x%03h good=%0d", n, f1, model_good(f1));
      run_frame("rand", f1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

PS/2 device-to-host receiver with a serial re-transmitter. It samples the open-collector PS/2 clock and data lines in the system `Clk` domain and assembles 11-bit frames. Each frame is checked for start, odd parity and stop, and the raw frame and a `valid` strobe are presented. The 8 data bits of every good frame are then shifted out on a simple clocked serial link. It sits between the keyboard/mouse connector pins and downstream serial consumers.

## Interface
- `TIMEOUT_CYCLES`, 1000: idle-high `Clk` cycles mid-frame that abort the frame.
- `SER_DIV`, 4: `serial_clk` half-period in `Clk` cycles.
- `Clk` input, 1 bit: system clock. All logic runs on its rising edge.
- `nReset` input, 1 bit: reset, asynchronous and active-low.
- `ps2_nclk` input, 1 bit: PS/2 clock line, asynchronous.
- `ndata` input, 1 bit: PS/2 data line, asynchronous.
- `serial_data` output, 11 bits: last completed frame.
  - [0] = start bit.
  - [8:1] = data, bit 1 is the LSB.
  - [9] = parity.
  - [10] = stop bit.
- `valid` output, 1 bit: one-cycle pulse when a good frame completes.
- `led` output, 1 bit: high when the last completed or aborted frame was bad; low after a good frame.
- `serial_clk` output, 1 bit: free-running divided clock, period 2*`SER_DIV` `Clk` cycles.
- `serial_clk_out` output, 1 bit: equals `serial_clk` while transmitting, otherwise 0.
- `serial_out` output, 1 bit: transmit data; idles at 1.

## Operation
- **Reset values:** `serial_data` = 0, `valid` = 0, `led` = 0, `serial_clk` = 0, `serial_clk_out` = 0, `serial_out` = 1. The bit counter, shift register and transmitter are cleared.
- **Synchronisation:** `ps2_nclk` and `ndata` each pass through a 2-flop synchroniser. A third flop holds the previous synchronised clock value. A falling edge is registered-previous = 1 and synchronised = 0.
- **Bit capture:** on each detected falling edge, the synchronised data bit shifts into an 11-bit register. Shifting is right-shift with the new bit entering at the MSB. The bit counter counts 0..10.
- **Frame completion:** at the 11th bit, the full register (including the bit being shifted in) loads into `serial_data` and the counter resets to 0.
  - The frame is good when start = 0, stop = 1, and there is an odd number of ones across data plus parity.
  - Good frame: `valid` = 1 for one cycle, `led` = 0, and the transmitter is loaded.
  - Bad frame: `valid` stays 0 and `led` = 1.
- **Timeout:** an idle counter runs while counter ≠ 0 and no falling edge occurs. When it reaches `TIMEOUT_CYCLES`, the counter and shift register clear, `led` = 1, and `serial_data` is unchanged.
- **Transmitter states:** IDLE, WAIT, SHIFT.
  - IDLE → WAIT when a good frame completes.
  - WAIT → SHIFT at the next falling edge of `serial_clk`.
  - In SHIFT, `serial_out` presents data bits LSB first, one per `serial_clk` period. Bits change only when `serial_clk` falls and are stable around its rise.
  - After 8 periods: SHIFT → IDLE and `serial_out` = 1.
- **Frame arriving while not IDLE:** `serial_data`, `valid` and `led` still update, but the transmitter ignores the new frame (it is dropped from transmission).

## Timing
- **Receive latency:** a `ps2_nclk` fall that meets setup at the first synchroniser flop is shifted in on the 3rd rising `Clk` edge. For the 11th bit, `serial_data` and `valid` update on that same 3rd edge.
- **Input rate:** correct for any PS/2 half-period ≥ 4 `Clk` cycles (for example, 5 cycles).
- **serial_clk_out:** outputs exactly 8 rising edges per transmitted byte.
- **Reset mid-frame or mid-transmission:** immediate return to reset values. No `valid` is produced for the partial frame.

## Structure
- **Package `ps2_pkg`:** `FRAME_BITS` = 11, the bit-index constants (`START_IDX` = 0, `DATA_LSB` = 1, `DATA_MSB` = 8, `PAR_IDX` = 9, `STOP_IDX` = 10), and the transmitter state enum.
- **Sub-module `ps2_serial_tx`:** the divider and the IDLE/WAIT/SHIFT transmitter.
- The top level holds the synchroniser, edge detect, shift register, checker and timeout.

## Test plan
- **Good frame, data 0x1C, parity 0:** bits 0, 0,0,1,1,1,0,0,0, 0, 1 → `serial_data` = 0x438, one `valid` pulse, `led` = 0. `serial_out` then carries 0,0,1,1,1,0,0,0 over 8 `serial_clk_out` pulses, then returns to 1.
- **Bad parity (0x1C with parity 1):** → `serial_data` = 0x638, no `valid`, `led` = 1, no `serial_clk_out` pulses.
- **Stop bit = 0 (0x1C, parity 0):** → `serial_data` = 0x038, no `valid`, `led` = 1.
- **Timeout:** 5 bits, then the clock held high for 1000 cycles → counter cleared, `led` = 1. A following frame of 0xF0 with parity 1 → `serial_data` = 0x7E0, `valid` pulses, `led` = 0.
- **Reset mid-frame:** `nReset` low after 6 bits → all outputs return to reset values. The next complete frame is received correctly.
- **Back-to-back good frames at 5-cycle half-period:** both produce `valid`. The second frame arrives while the first is still transmitting and is not transmitted.
